// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the per-slave round-robin AXI arbiter.
package axi_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned DEFAULT_TO_CYCLES = 1024;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority picker: first set bit of valid at or after start, mod NUM_M.
module arb_rr_pick #(
  parameter int unsigned NUM_M = 3,
  localparam int unsigned IW = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] valid,
  input  logic [IW-1:0]    start,
  output logic             found,
  output logic [IW-1:0]    idx
);

  always_comb begin
    int unsigned c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      c = (32'(start) + k) % NUM_M;
      if (!found && valid[c]) begin
        found = 1'b1;
        idx   = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Per-slave round-robin AXI arbiter with CPU/DMA class exclusion and per-grant direction.
// Optional hang watchdog compiled in with AXI_ARB_TIMEOUT_EN.
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned       NUM_M     = 3,
  parameter logic [NUM_M-1:0]  DMA_MASK  = 3'b100,
  parameter int unsigned       TO_CYCLES = DEFAULT_TO_CYCLES,
  localparam int unsigned      IW        = $clog2(NUM_M)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [NUM_M-1:0] req,
  input  logic [NUM_M-1:0] req_rw,
  input  logic [NUM_M-1:0] end_r,
  input  logic [NUM_M-1:0] end_w,
  input  logic [NUM_M-1:0] blocked,
  input  logic             other_cpu_busy,
  input  logic             other_dma_busy,
  output logic [NUM_M-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_rw,
  output logic [NUM_M-1:0] this_busy,
  output logic             cpu_busy,
  output logic             dma_busy,
  output logic             timeout_err
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic          dir_q, dir_d;

  logic [NUM_M-1:0] valid;
  logic [IW-1:0]    start;
  logic             found;
  logic [IW-1:0]    pick_idx;
  logic             pick;
  logic             end_hit;
  logic             expire;

  function automatic logic [IW-1:0] inc_idx(logic [IW-1:0] i);
    if (32'(i) == NUM_M - 1) return '0;
    return i + IW'(1);
  endfunction

  // DMA masters additionally yield to any CPU traffic on sibling slaves.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      valid[i] = req[i] & ~blocked[i] & ~other_dma_busy & (~DMA_MASK[i] | ~other_cpu_busy);
    end
  end

  assign start = inc_idx((state_q == BUSY) ? owner_q : last_q);

  arb_rr_pick #(
    .NUM_M (NUM_M)
  ) u_pick (
    .valid (valid),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );

  assign end_hit = (state_q == BUSY) && ((dir_q == RW_READ) ? end_r[owner_q] : end_w[owner_q]);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    last_d  = last_q;
    pick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) pick = 1'b1;
      end
      BUSY: begin
        if (end_hit || expire) begin
          last_d = owner_q;
          if (found) pick = 1'b1;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pick) begin
      state_d = BUSY;
      owner_d = pick_idx;
      dir_d   = req_rw[pick_idx];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      owner_q <= '0;
      dir_q   <= 1'b0;
      last_q  <= IW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q;

  assign expire = (state_q == BUSY) && !end_hit && (cnt_q == CW'(TO_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (pick)                  cnt_d = '0;
    else if (state_q == BUSY)  cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= expire;
    end
  end

  assign timeout_err = tout_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // All grant-side outputs decode from registered state only.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_rw  = 1'b0;
    cpu_busy  = 1'b0;
    dma_busy  = 1'b0;
    if (state_q == BUSY) begin
      grant[owner_q] = 1'b1;
      grant_idx      = owner_q;
      grant_rw       = dir_q;
      cpu_busy       = ~DMA_MASK[owner_q];
      dma_busy       = DMA_MASK[owner_q];
    end
  end

  assign this_busy = grant;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed table-driven bench for axi_rr_arbiter (NUM_M=3, master 2 is DMA class).
module tb_axi_rr_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [2:0] req, req_rw, end_r, end_w, blocked;
  logic       other_cpu_busy, other_dma_busy;
  logic [2:0] grant, this_busy;
  logic [1:0] grant_idx;
  logic       grant_rw, cpu_busy, dma_busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi_rr_arbiter #(
    .NUM_M     (3),
    .DMA_MASK  (3'b100),
    .TO_CYCLES (16)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .req            (req),
    .req_rw         (req_rw),
    .end_r          (end_r),
    .end_w          (end_w),
    .blocked        (blocked),
    .other_cpu_busy (other_cpu_busy),
    .other_dma_busy (other_dma_busy),
    .grant          (grant),
    .grant_idx      (grant_idx),
    .grant_rw       (grant_rw),
    .this_busy      (this_busy),
    .cpu_busy       (cpu_busy),
    .dma_busy       (dma_busy),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    logic       rst;
    logic [2:0] req, rw, er, ew, blk;
    logic       ocb, odb;
    logic [2:0] g;
    logic [1:0] idx;
    logic       grw, cpu, dma;
  } vec_t;

  vec_t tv[23];

  function automatic vec_t mk(logic rst, logic [2:0] rq, logic [2:0] rw, logic [2:0] er,
                              logic [2:0] ew, logic [2:0] blk, logic ocb, logic odb,
                              logic [2:0] g, logic [1:0] idx, logic grw, logic cpu,
                              logic dma);
    vec_t v;
    v.rst = rst; v.req = rq; v.rw = rw; v.er = er; v.ew = ew; v.blk = blk;
    v.ocb = ocb; v.odb = odb; v.g = g; v.idx = idx; v.grw = grw; v.cpu = cpu; v.dma = dma;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    ARESET = 1'b0; req = '0; req_rw = '0; end_r = '0; end_w = '0; blocked = '0;
    other_cpu_busy = 1'b0; other_dma_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
  endtask

  initial begin
    //        rst req    rw     er     ew     blk    ocb odb  g      idx grw cpu dma
    tv[0]  = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
    // master 1 write grant: wrong-direction and non-owner ends are ignored
    tv[1]  = mk(0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b010, 1, 0, 1, 0);
    tv[2]  = mk(0, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 3'b010, 1, 0, 1, 0);
    tv[3]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 0, 0, 3'b010, 1, 0, 1, 0);
    tv[4]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b010, 1, 0, 1, 0);
    tv[5]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
    // other_dma_busy holds everyone off; last=1 so scan 2,0,1 picks 0
    tv[6]  = mk(0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 0, 0);
    tv[7]  = mk(0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 0, 0);
    tv[8]  = mk(0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b001, 0, 0, 1, 0);
    tv[9]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
    // DMA master 2 excluded by other_cpu_busy, CPU master 0 still granted (read)
    tv[10] = mk(0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0);
    tv[11] = mk(0, 3'b101, 3'b001, 3'b000, 3'b000, 3'b000, 1, 0, 3'b001, 0, 1, 1, 0);
    tv[12] = mk(0, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 1, 0, 3'b001, 0, 1, 1, 0);
    tv[13] = mk(0, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000, 0, 0, 3'b100, 2, 0, 0, 1);
    // ocb rising during a DMA grant does not revoke it
    tv[14] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 3'b100, 2, 0, 0, 1);
    tv[15] = mk(0, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
    // reset mid-grant restores master 0 priority (without it last=0 would pick 1)
    tv[16] = mk(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b001, 0, 0, 1, 0);
    tv[17] = mk(0, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 0, 0, 3'b010, 1, 0, 1, 0);
    tv[18] = mk(1, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
    tv[19] = mk(0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b001, 0, 0, 1, 0);
    tv[20] = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);
    // blocked master skipped
    tv[21] = mk(0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 0, 0, 3'b010, 1, 0, 1, 0);
    tv[22] = mk(0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0);

    idle_inputs();
    tick();
    for (int i = 0; i < 23; i++) begin
      ARESET = tv[i].rst; req = tv[i].req; req_rw = tv[i].rw; end_r = tv[i].er;
      end_w = tv[i].ew; blocked = tv[i].blk; other_cpu_busy = tv[i].ocb;
      other_dma_busy = tv[i].odb;
      tick();
      chk("grant", i, 32'(grant), 32'(tv[i].g));
      chk("grant_idx", i, 32'(grant_idx), 32'(tv[i].idx));
      chk("grant_rw", i, 32'(grant_rw), 32'(tv[i].grw));
      chk("cpu_busy", i, 32'(cpu_busy), 32'(tv[i].cpu));
      chk("dma_busy", i, 32'(dma_busy), 32'(tv[i].dma));
      chk("this_busy", i, 32'(this_busy), 32'(tv[i].g));
      chk("timeout_err", i, 32'(timeout_err), 32'(0));
    end

    // Round robin with all three requesting; each transaction ends 4 cycles after grant.
    do_reset();
    req = 3'b111;
    tick();
    chk("rr_first", 0, 32'(grant), 32'(3'b001));
    for (int t = 0; t < 6; t++) begin
      for (int c = 1; c <= 4; c++) begin
        end_w = (c == 4) ? (3'b001 << (t % 3)) : 3'b000;
        tick();
        if (c == 4) chk("rr_handover", t, 32'(grant), 32'(3'b001 << ((t + 1) % 3)));
        else        chk("rr_hold", t * 4 + c, 32'(grant), 32'(3'b001 << (t % 3)));
      end
    end
    end_w = '0;

    // Watchdog: master 0 granted and never ends.
    do_reset();
    req = 3'b001;
    tick();
    chk("wd_grant", 0, 32'(grant), 32'(3'b001));
    req = 3'b000;
`ifdef AXI_ARB_TIMEOUT_EN
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c < 16) begin
        chk("wd_hold", c, 32'(grant), 32'(3'b001));
        chk("wd_no_pulse", c, 32'(timeout_err), 32'(0));
      end else if (c == 16) begin
        chk("wd_release", c, 32'(grant), 32'(3'b000));
        chk("wd_pulse", c, 32'(timeout_err), 32'(1));
      end else begin
        chk("wd_pulse_end", c, 32'(timeout_err), 32'(0));
      end
    end
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c % 20 == 0) begin
        chk("wd_held", c, 32'(grant), 32'(3'b001));
        chk("wd_no_pulse", c, 32'(timeout_err), 32'(0));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
